// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing, 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // 50 MHz system clock / 115200 baud
    localparam int unsigned DIVN_DEFAULT = 434;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/uart_rx_core_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to a configurable idle value.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizes rxd, validates the start bit at half-bit, samples data and stop mid-bit.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DIVN = DIVN_DEFAULT,
    parameter int unsigned CW   = 16
) (
    input  logic                 fin,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned   IW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVN / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVN - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    logic                 rx_s;
    logic                 rx_d_q, rx_d_d;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic                 half_hit, bit_hit, stop_pt;

    sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(fin),
        .rst(reset),
        .d  (rxd),
        .q  (rx_s)
    );

    assign half_hit = (cnt_q == HALF_LAST);
    assign bit_hit  = (cnt_q == BIT_LAST);
    assign stop_pt  = (state_q == STOP) && bit_hit;

    always_ff @(posedge fin or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter is cleared at every sample point, so it never needs to wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        rx_d_d  = rx_s;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_d_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (half_hit) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_hit) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            STOP: begin
                if (bit_hit) begin
                    cnt_d = '0;
                    if (!rx_s || idx_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d     = stop_pt && rx_s && (idx_q == STOP_LAST);
        frame_err_d = stop_pt && !rx_s;
        data_d      = valid_d ? shift_q : data_q;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge fin or posedge reset) begin
        if (reset) begin
            rx_d_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_d_q      <= rx_d_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Frame-level bench for uart_rx_core: random 8N1 frames with edge jitter, compared against an event-queue model.
module tb_uart_rx_core;

    localparam int DIVN = 8;

    logic       fin;
    logic       reset;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: expected events {is_err, data seen at the pulse}, in order.
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic [7:0] last_good;
    int         exp_rises;

    int   busy_rises = 0;
    int   both_hi    = 0;
    int   cur_len    = 0;
    int   last_len   = 0;
    logic busy_prev  = 1'b0;

    uart_rx_core #(
        .DIVN(DIVN),
        .CW  (4)
    ) dut (
        .fin      (fin),
        .reset    (reset),
        .rxd      (rxd),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial fin = 1'b0;
    always #5 fin = ~fin;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge fin) begin
        if (valid || frame_err) obs_q.push_back({frame_err, data});
        if (valid && frame_err) both_hi++;
        if (busy && !busy_prev) busy_rises++;
        if (busy) cur_len++;
        if (!busy && busy_prev) begin
            last_len = cur_len;
            cur_len  = 0;
        end
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
    endtask

    // Bit boundaries move by at most one cycle from nominal, so skew never accumulates.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit jit, input int abort_at);
        logic [9:0] bits;
        int off_prev, off, len;
        bits      = {stop, b, 1'b0};
        off_prev  = 0;
        exp_rises++;
        for (int k = 0; k < 10; k++) begin
            off      = (jit && k < 9) ? int'($urandom_range(2)) - 1 : 0;
            len      = DIVN + off - off_prev;
            off_prev = off;
            rxd      = bits[k];
            if (k == abort_at) begin
                repeat (DIVN / 2) @(negedge fin);
                return;
            end
            repeat (len) @(negedge fin);
        end
        if (abort_at < 0) expect_frame(b, stop);
    endtask

    task automatic drain(input string tag);
        int n;
        rxd = 1'b1;
        repeat (3 * DIVN) @(negedge fin);
        check({tag, ":n_events"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s:ev%0d_err", tag, i), obs_q[i][8], exp_q[i][8]);
            check($sformatf("%s:ev%0d_data", tag, i), obs_q[i][7:0], exp_q[i][7:0]);
        end
        check({tag, ":busy_rises"}, busy_rises, exp_rises);
        check({tag, ":data_hold"}, data, last_good);
        check({tag, ":valid_and_err"}, both_hi, 0);
        check({tag, ":idle"}, busy, 1'b0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        @(negedge fin);
        #2;
        reset = 1'b1;
        #1;
        check({tag, ":data"}, data, 8'h00);
        check({tag, ":valid"}, valid, 1'b0);
        check({tag, ":frame_err"}, frame_err, 1'b0);
        check({tag, ":busy"}, busy, 1'b0);
        rxd = 1'b1;
        repeat (3) @(negedge fin);
        reset     = 1'b0;
        last_good = 8'h00;
        obs_q.delete();
        exp_q.delete();
        repeat (2) @(negedge fin);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         gap;

        reset     = 1'b1;
        rxd       = 1'b1;
        last_good = 8'h00;
        exp_rises = 0;
        repeat (3) @(negedge fin);
        check("rst0:data", data, 8'h00);
        check("rst0:busy", busy, 1'b0);
        check("rst0:valid", valid, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge fin);

        send_frame(8'hA5, 1'b1, 1'b0, -1);
        drain("good_a5");

        rxd = 1'b0;
        repeat (2) @(negedge fin);
        rxd = 1'b1;
        exp_rises++;
        repeat (2 * DIVN) @(negedge fin);
        check("glitch:busy_len_about_4", (last_len >= 3 && last_len <= 5), 1'b1);
        drain("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, -1);
        rxd = 1'b0;
        repeat (3 * DIVN) @(negedge fin);
        check("held_low:no_retrigger", busy_rises, exp_rises);
        drain("frame_err");

        send_frame(8'h00, 1'b1, 1'b1, -1);
        send_frame(8'hFF, 1'b1, 1'b1, -1);
        drain("back_to_back");

        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(3) != 0);
            send_frame(b, stop, 1'b1, -1);
            gap = stop ? int'($urandom_range(DIVN)) : int'($urandom_range(DIVN, 3));
            rxd = 1'b1;
            repeat (gap) @(negedge fin);
        end
        drain("random");

        do_reset("rst_idle");

        send_frame(8'h5A, 1'b1, 1'b0, 5);
        check("midframe:busy_before_reset", busy, 1'b1);
        do_reset("rst_midframe");
        send_frame(8'h81, 1'b1, 1'b0, -1);
        drain("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receiver for 8N1 asynchronous frames; the receive end of the 115200-baud serial link whose bit timing the lab clock divider produces. Samples the raw `rxd` pin with the system clock, detects and validates the start bit, recovers 8 data bits LSB-first at mid-bit, checks the stop bit, and presents each byte with a one-cycle `valid` pulse. Sits between the board pin and any byte consumer (display, FIFO, command decoder).

## Interface
- `DIVN`, 434: system clocks per bit (434 at 50 MHz gives 115200 baud); legal range 4..65535.
- `CW`, 16: bit-counter width; must hold DIVN-1.
- `fin`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  raw serial line, idle high, asynchronous to `fin`.
- `data`  out  8  last received byte; held until next good frame.
- `valid`  out  1  one-cycle pulse, `data` newly updated.
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low.
- `busy`  out  1  high from start-bit detection until frame end.

## Operation
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, counters 0, synchronizer flops 1.
- `rxd` passes through 2-flop synchronizer (`rx_s`), plus one delay flop (`rx_d`) for edge detection.
- States: IDLE, START, DATA, STOP.
- IDLE: on `rx_d`=1 and `rx_s`=0 (falling edge) -> START, clear clock counter `cnt`. A line held low does not retrigger.
- START: `cnt` counts up; at `cnt`==DIVN/2-1 (integer divide) sample `rx_s`: 0 -> DATA, `cnt` cleared, bit index 0; 1 -> glitch, back to IDLE, no output pulse.
- DATA: at `cnt`==DIVN-1 sample `rx_s` into shift register bit [idx] (LSB first), clear `cnt`; after idx 7 -> STOP.
- STOP: at `cnt`==DIVN-1 sample `rx_s`: 1 -> load `data`, pulse `valid`; 0 -> pulse `frame_err`, `data` unchanged. Either way -> IDLE same edge.
- `busy` = (state != IDLE), registered.
- `valid` and `frame_err` never high together.
- Reset mid-frame: immediate return to reset values; partial byte discarded.
- Counter never wraps: cleared at every sample point; compare uses CW-bit unsigned arithmetic.

## Timing
- Sync latency: `rx_s` follows `rxd` by 2 `fin` edges.
- Start sample: DIVN/2 cycles after falling edge seen in IDLE.
- Each data bit sampled DIVN cycles after previous sample (mid-bit).
- `valid` asserted on the edge that samples the stop bit: 2 + DIVN/2 + 9*DIVN cycles (+/-1 for edge alignment) after `rxd` falls.
- Back-to-back frames: IDLE re-entered at stop-bit middle; next start edge accepted from the following cycle, tolerating up to ~DIVN/2 baud skew.
- `data` stable from `valid` until next `valid`.

## Structure
- Shared package `uart_pkg`: state enum (IDLE/START/DATA/STOP, 2-bit), default `DIVN`, frame constants (8 data bits, 1 stop bit).
- One natural sub-module: `sync2`, 2-flop synchronizer with reset value 1, reusable by the future transmitter's handshake inputs.
- Bit-timing counter and FSM stay in `uart_rx_core`.

## Test plan
- Reset: assert `reset` mid-simulation with `rxd`=1 -> all outputs 0, `busy`=0 same cycle (async).
- Good frame, DIVN=8: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> single `valid` pulse, `data`=8'hA5, `frame_err`=0, `busy` high throughout.
- Glitch: `rxd` low for 2 cycles then high, DIVN=8 -> `busy` pulses ~4 cycles, no `valid`/`frame_err`, returns IDLE.
- Framing error: send 0x3C with stop bit 0 -> `frame_err` one pulse, no `valid`, `data` keeps previous 0xA5; line held low afterward does not start a new frame until a fresh falling edge.
- Back-to-back: 0x00 then 0xFF with no idle gap, plus +/-1 cycle per-bit skew -> two `valid` pulses, `data` 0x00 then 0xFF.
- Reset mid-frame: assert `reset` during bit 4 of 0x5A, release, send 0x81 -> only one `valid`, `data`=8'h81.
